// File: rtl/lbdr_pkg.sv
// lbdr_pkg: shared definitions for the LBDR-with-deroute routing unit.
//   - flit-id encodings seen on in_id
//   - output port index enum (bit positions of the one-hot port request)
//   - routing FSM state enum
//   - configuration register reset values
package lbdr_pkg;

    // Flit types; bit 0 marks a header-class flit, bit 2 marks a tail-class flit.
    localparam logic [2:0] FLIT_PAYLOAD   = 3'b000;
    localparam logic [2:0] FLIT_HEADER    = 3'b001;
    localparam logic [2:0] FLIT_TAIL      = 3'b100;
    localparam logic [2:0] FLIT_HEAD_TAIL = 3'b101;

    // Bit index in the one-hot request {L,S,W,E,N}. The first four values
    // double as the 2-bit deroute port codes (00=N, 01=E, 10=W, 11=S).
    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUTE = 1'b1
    } state_e;

    // Reset configuration: XY-style turn bits, all ports connected,
    // every deroute pointing north, router address 5.
    localparam logic [7:0] RXY_RST = 8'h3C;
    localparam logic [3:0] CX_RST  = 4'hF;
    localparam logic [7:0] DR_RST  = 8'h00;
    localparam int         CUR_RST = 5;

endpackage

// File: rtl/lbdr_route_calc.sv
// lbdr_route_calc: combinational LBDR route computation with deroute fallback.
// Ports:
//   rxy         routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cx          connectivity bits {Cs,Cw,Ce,Cn}
//   dr          deroute codes, 2 bits each {S,W,E,N}
//   cur, dst    this router / destination address {y, x}
//   port_onehot one-hot request {L,S,W,E,N}; zero when unroutable
//   unroutable  no minimal port and the deroute port is disconnected
module lbdr_route_calc
    import lbdr_pkg::*;
#(
    parameter int XW = 2,
    parameter int YW = 2
) (
    input  logic [7:0]       rxy,
    input  logic [3:0]       cx,
    input  logic [7:0]       dr,
    input  logic [XW+YW-1:0] cur,
    input  logic [XW+YW-1:0] dst,
    output logic [4:0]       port_onehot,
    output logic             unroutable
);

    logic [XW-1:0] x_cur, x_dst;
    logic [YW-1:0] y_cur, y_dst;
    logic          n1, s1, e1, w1, local_hit;
    logic          m_n, m_e, m_w, m_s;
    logic [1:0]    dr_code;

    assign x_cur = cur[XW-1:0];
    assign y_cur = cur[XW+YW-1:XW];
    assign x_dst = dst[XW-1:0];
    assign y_dst = dst[XW+YW-1:XW];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;
    assign local_hit = ~(n1 | s1 | e1 | w1);

    assign m_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
    assign m_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
    assign m_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
    assign m_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];

    // Deroute code of the primary direction, priority N, S, E, W.
    always_comb begin
        dr_code = dr[5:4];
        if (n1)      dr_code = dr[1:0];
        else if (s1) dr_code = dr[7:6];
        else if (e1) dr_code = dr[3:2];
    end

    // Two minimal ports can both be enabled by the turn bits; the same
    // N, S, E, W priority keeps the request one-hot.
    always_comb begin
        port_onehot = '0;
        unroutable  = 1'b0;
        if (local_hit)    port_onehot[PORT_L] = 1'b1;
        else if (m_n)     port_onehot[PORT_N] = 1'b1;
        else if (m_s)     port_onehot[PORT_S] = 1'b1;
        else if (m_e)     port_onehot[PORT_E] = 1'b1;
        else if (m_w)     port_onehot[PORT_W] = 1'b1;
        else if (cx[dr_code]) port_onehot[dr_code] = 1'b1;
        else              unroutable = 1'b1;
    end

endmodule

// File: rtl/lbdr_dr.sv
// lbdr_dr: per-input-port LBDR routing unit with deroutes, packet-level
// route holding and a runtime configuration port.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cfg_we/rxy/cx/dr/addr      configuration write (deferred while a packet is routed)
//   in_valid, in_id, in_dst    flit at the input buffer head
//   in_ready                   flit consumed this cycle (combinational)
//   out_ready                  switch grant for the held port
//   port_req                   registered one-hot request {L,S,W,E,N}
//   route_err, stray           one-cycle drop indications
//   pkt_cnt                    completed packet counter (wraps)
module lbdr_dr
    import lbdr_pkg::*;
#(
    parameter int XW  = 2,
    parameter int YW  = 2,
    parameter int IDW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_rxy,
    input  logic [3:0]       cfg_cx,
    input  logic [7:0]       cfg_dr,
    input  logic [XW+YW-1:0] cfg_addr,
    input  logic             in_valid,
    input  logic [IDW-1:0]   in_id,
    input  logic [XW+YW-1:0] in_dst,
    output logic             in_ready,
    input  logic             out_ready,
    output logic [4:0]       port_req,
    output logic             route_err,
    output logic             stray,
    output logic [15:0]      pkt_cnt
);

    localparam int AW = XW + YW;
    localparam logic [IDW-1:0] ID_HEADER    = IDW'(FLIT_HEADER);
    localparam logic [IDW-1:0] ID_TAIL      = IDW'(FLIT_TAIL);
    localparam logic [IDW-1:0] ID_HEAD_TAIL = IDW'(FLIT_HEAD_TAIL);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          hdr_seen_q, hdr_seen_d;
    logic [4:0]    port_req_q, port_req_d;
    logic          route_err_q, route_err_d;
    logic          stray_q, stray_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic [7:0]    rxy_q, rxy_d;
    logic [3:0]    cx_q, cx_d;
    logic [7:0]    dr_q, dr_d;
    logic [AW-1:0] cur_q, cur_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_rxy_q, pend_rxy_d;
    logic [3:0]    pend_cx_q, pend_cx_d;
    logic [7:0]    pend_dr_q, pend_dr_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;

    logic [4:0]    calc_port;
    logic          calc_unroutable;
    logic          is_hdr, done;

    lbdr_route_calc #(.XW(XW), .YW(YW)) u_calc (
        .rxy         (rxy_q),
        .cx          (cx_q),
        .dr          (dr_q),
        .cur         (cur_q),
        .dst         (in_dst),
        .port_onehot (calc_port),
        .unroutable  (calc_unroutable)
    );

    assign is_hdr = (in_id == ID_HEADER) || (in_id == ID_HEAD_TAIL);

    // In ROUTE only body flits move; a header waits for IDLE. While a
    // HEAD_TAIL is completing nothing more is taken from the buffer, since
    // that flit was already consumed in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) in_ready = 1'b1;
        else                    in_ready = in_valid & out_ready & ~is_hdr & ~last_q;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hdr_seen_d  = hdr_seen_q;
        port_req_d  = port_req_q;
        route_err_d = 1'b0;
        stray_d     = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        rxy_d       = rxy_q;
        cx_d        = cx_q;
        dr_d        = dr_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pend_rxy_d  = pend_rxy_q;
        pend_cx_d   = pend_cx_q;
        pend_dr_d   = pend_dr_q;
        pend_addr_d = pend_addr_q;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hdr_seen_d = 1'b0;
                if (in_valid) begin
                    if (!is_hdr) begin
                        stray_d = 1'b1;
                    end else if (calc_unroutable) begin
                        route_err_d = 1'b1;
                    end else begin
                        port_req_d = calc_port;
                        state_d    = ST_ROUTE;
                        last_d     = (in_id == ID_HEAD_TAIL);
                    end
                end
                if (cfg_we) begin
                    rxy_d = cfg_rxy;
                    cx_d  = cfg_cx;
                    dr_d  = cfg_dr;
                    cur_d = cfg_addr;
                end
            end
            default: begin
                // Pulse stray only on the first cycle a stalled header is seen.
                stray_d    = in_valid & is_hdr & ~hdr_seen_q;
                hdr_seen_d = in_valid & is_hdr;
                done       = last_q ? out_ready : (in_ready && in_id == ID_TAIL);
                if (cfg_we) begin
                    pend_d      = 1'b1;
                    pend_rxy_d  = cfg_rxy;
                    pend_cx_d   = cfg_cx;
                    pend_dr_d   = cfg_dr;
                    pend_addr_d = cfg_addr;
                end
                // Deferred config lands on the same edge that re-enters IDLE,
                // so a header arriving right away already sees it.
                if (done) begin
                    state_d    = ST_IDLE;
                    last_d     = 1'b0;
                    port_req_d = '0;
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    pend_d     = 1'b0;
                    if (cfg_we) begin
                        rxy_d = cfg_rxy;
                        cx_d  = cfg_cx;
                        dr_d  = cfg_dr;
                        cur_d = cfg_addr;
                    end else if (pend_q) begin
                        rxy_d = pend_rxy_q;
                        cx_d  = pend_cx_q;
                        dr_d  = pend_dr_q;
                        cur_d = pend_addr_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b0;
            hdr_seen_q  <= 1'b0;
            port_req_q  <= '0;
            route_err_q <= 1'b0;
            stray_q     <= 1'b0;
            pkt_cnt_q   <= '0;
            rxy_q       <= RXY_RST;
            cx_q        <= CX_RST;
            dr_q        <= DR_RST;
            cur_q       <= AW'(CUR_RST);
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hdr_seen_q  <= hdr_seen_d;
            port_req_q  <= port_req_d;
            route_err_q <= route_err_d;
            stray_q     <= stray_d;
            pkt_cnt_q   <= pkt_cnt_d;
            rxy_q       <= rxy_d;
            cx_q        <= cx_d;
            dr_q        <= dr_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
        end
    end

    // Pending values are only read when pend_q is set, so they need no reset.
    always_ff @(posedge clk) begin
        pend_rxy_q  <= pend_rxy_d;
        pend_cx_q   <= pend_cx_d;
        pend_dr_q   <= pend_dr_d;
        pend_addr_q <= pend_addr_d;
    end

    assign port_req  = port_req_q;
    assign route_err = route_err_q;
    assign stray     = stray_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_lbdr_dr.sv
// tb_lbdr_dr: directed testbench for lbdr_dr with hand-computed expectations.
module tb_lbdr_dr;

    localparam logic [2:0] PAYLOAD   = 3'b000;
    localparam logic [2:0] HEADER    = 3'b001;
    localparam logic [2:0] TAIL      = 3'b100;
    localparam logic [2:0] HEAD_TAIL = 3'b101;
    // one-hot {L,S,W,E,N}
    localparam logic [4:0] P_N = 5'b00001;
    localparam logic [4:0] P_E = 5'b00010;
    localparam logic [4:0] P_W = 5'b00100;
    localparam logic [4:0] P_S = 5'b01000;
    localparam logic [4:0] P_L = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [7:0]  cfg_rxy;
    logic [3:0]  cfg_cx;
    logic [7:0]  cfg_dr;
    logic [3:0]  cfg_addr;
    logic        in_valid;
    logic [2:0]  in_id;
    logic [3:0]  in_dst;
    logic        in_ready;
    logic        out_ready;
    logic [4:0]  port_req;
    logic        route_err;
    logic        stray;
    logic [15:0] pkt_cnt;

    int errors = 0;
    int checks = 0;

    lbdr_dr #(.XW(2), .YW(2), .IDW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_rxy   (cfg_rxy),
        .cfg_cx    (cfg_cx),
        .cfg_dr    (cfg_dr),
        .cfg_addr  (cfg_addr),
        .in_valid  (in_valid),
        .in_id     (in_id),
        .in_dst    (in_dst),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .port_req  (port_req),
        .route_err (route_err),
        .stray     (stray),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_rxy = 8'h3C; cfg_cx = 4'hF; cfg_dr = 8'h00;
        cfg_addr = 4'd5; in_valid = 1'b0; in_id = PAYLOAD; in_dst = 4'd0; out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] id, input logic [3:0] dst, input logic ordy);
        in_valid = 1'b1; in_id = id; in_dst = dst; out_ready = ordy;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic write_cfg(input logic [7:0] rxy, input logic [3:0] cx,
                             input logic [7:0] drv, input logic [3:0] addr);
        cfg_we = 1'b1; cfg_rxy = rxy; cfg_cx = cx; cfg_dr = drv; cfg_addr = addr;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL reset_port_req: got %b want %b", port_req, 5'b0); end
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL reset_route_err: got %b want 0", route_err); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b want 0", stray); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_minimal();
        logic [3:0] dsts [3];
        logic [4:0] exps [3];
        dsts[0] = 4'd0;  exps[0] = P_W;
        dsts[1] = 4'd5;  exps[1] = P_L;
        dsts[2] = 4'd15; exps[2] = P_E;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(HEADER, dsts[i], 1'b0);
            checks++; if (port_req !== exps[i]) begin errors++; $display("FAIL minimal_dst%0d: got %b want %b", dsts[i], port_req, exps[i]); end
            send(TAIL, 4'd0, 1'b1);
            checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL minimal_clear%0d: got %b want 0", i, port_req); end
        end
        checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL minimal_pkt_cnt: got %0d want 3", pkt_cnt); end
    endtask

    task automatic test_deroute();
        do_reset();
        write_cfg(8'h3C, 4'b1101, 8'b0000_1100, 4'd5);
        send(HEADER, 4'd7, 1'b0);
        checks++; if (port_req !== P_S) begin errors++; $display("FAIL deroute_port: got %b want %b", port_req, P_S); end
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL deroute_no_err: got %b want 0", route_err); end
        send(TAIL, 4'd0, 1'b1);
        write_cfg(8'h3C, 4'b0101, 8'b0000_1100, 4'd5);
        send(HEADER, 4'd7, 1'b0);
        checks++; if (route_err !== 1'b1) begin errors++; $display("FAIL unroutable_err: got %b want 1", route_err); end
        checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL unroutable_port: got %b want 0", port_req); end
        // Still IDLE: a flit is taken even with out_ready low.
        in_valid = 1'b1; in_id = PAYLOAD; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unroutable_idle: in_ready got %b want 1", in_ready); end
        in_valid = 1'b0;
        cyc();
        checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL unroutable_pulse: got %b want 0", route_err); end
    endtask

    task automatic test_packet_hold();
        logic [2:0] flits [4];
        int idx;
        flits[0] = PAYLOAD; flits[1] = PAYLOAD; flits[2] = PAYLOAD; flits[3] = TAIL;
        do_reset();
        send(HEADER, 4'd15, 1'b0);
        idx = 0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            in_valid = 1'b1; in_id = flits[idx]; in_dst = 4'd0; out_ready = (k % 2 == 0);
            #1;
            checks++; if (in_ready !== out_ready) begin errors++; $display("FAIL hold_in_ready%0d: got %b want %b", k, in_ready, out_ready); end
            checks++; if (port_req !== P_E) begin errors++; $display("FAIL hold_port%0d: got %b want %b", k, port_req, P_E); end
            cyc();
            if (out_ready) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (idx !== 4) begin errors++; $display("FAIL hold_transfers: got %0d want 4", idx); end
        checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL hold_clear: got %b want 0", port_req); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL hold_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(HEAD_TAIL, 4'd0, 1'b1);
        checks++; if (port_req !== P_W) begin errors++; $display("FAIL ht_port: got %b want %b", port_req, P_W); end
        in_valid = 1'b1; in_id = HEADER; in_dst = 4'd15; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ht_hdr_stall: got %b want 0", in_ready); end
        cyc();
        checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL ht_clear: got %b want 0", port_req); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL ht_pkt_cnt: got %0d want 1", pkt_cnt); end
        checks++; if (stray !== 1'b1) begin errors++; $display("FAIL ht_hdr_stray: got %b want 1", stray); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ht_idle_ready: got %b want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (port_req !== P_E) begin errors++; $display("FAIL b2b_port: got %b want %b", port_req, P_E); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL b2b_stray: got %b want 0", stray); end
        send(TAIL, 4'd0, 1'b1);
        checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL b2b_pkt_cnt: got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_cfg_in_route();
        do_reset();
        send(HEADER, 4'd0, 1'b0);
        write_cfg(8'h3C, 4'hF, 8'h00, 4'd0);
        checks++; if (port_req !== P_W) begin errors++; $display("FAIL cfg_hold_port: got %b want %b", port_req, P_W); end
        send(PAYLOAD, 4'd0, 1'b1);
        checks++; if (port_req !== P_W) begin errors++; $display("FAIL cfg_hold_body: got %b want %b", port_req, P_W); end
        send(TAIL, 4'd0, 1'b1);
        send(HEADER, 4'd5, 1'b0);
        checks++; if (port_req !== P_E) begin errors++; $display("FAIL cfg_applied: got %b want %b", port_req, P_E); end
        send(TAIL, 4'd0, 1'b1);
    endtask

    task automatic test_errors();
        do_reset();
        send(PAYLOAD, 4'd0, 1'b0);
        checks++; if (stray !== 1'b1) begin errors++; $display("FAIL stray_pulse: got %b want 1", stray); end
        checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL stray_port: got %b want 0", port_req); end
        cyc();
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL stray_one_cycle: got %b want 0", stray); end
        send(HEADER, 4'd15, 1'b0);
        checks++; if (port_req !== P_E) begin errors++; $display("FAIL midrst_port: got %b want %b", port_req, P_E); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (port_req !== 5'b0) begin errors++; $display("FAIL midrst_clear: got %b want 0", port_req); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b want 1", in_ready); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL midrst_pkt_cnt: got %0d want 0", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_deroute();
        test_packet_hold();
        test_back_to_back();
        test_cfg_in_route();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lbdr_dr.md
# lbdr_dr

Parametrised Logic-Based Distributed Routing unit with deroutes, packet-level route holding and a runtime configuration port. It sits at each router input port, between the input buffer and the switch allocator. It computes a one-hot output-port request from a header flit's destination and holds that request until the packet's tail is transferred. It generalises the minimal LBDR: configurable mesh coordinate widths, a deroute fallback when no minimal port is usable, and a valid/ready flit handshake.

## Interface
- `XW`, default 2: width of the X coordinate field of an address.
- `YW`, default 2: width of the Y coordinate field; the address is `{y, x}` with width `XW+YW`.
- `IDW`, default 3: width of the flit-id field.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_we`, in, 1: configuration write strobe.
- `cfg_rxy`, in, 8: routing bits, in order `{Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}`.
- `cfg_cx`, in, 4: connectivity bits `{Cs,Cw,Ce,Cn}`.
- `cfg_dr`, in, 8: deroute port code, 2 bits per primary direction `{S,W,E,N}`. Codes: 00=N, 01=E, 10=W, 11=S.
- `cfg_addr`, in, `XW+YW`: this router's address.
- `in_valid`, in, 1: flit present at the input buffer head.
- `in_id`, in, `IDW`: flit type.
- `in_dst`, in, `XW+YW`: destination field; meaningful on headers only.
- `in_ready`, out, 1: flit consumed this cycle.
- `out_ready`, in, 1: the switch has granted the held port and the downstream can accept.
- `port_req`, out, 5: one-hot `{L,S,W,E,N}`, registered.
- `route_err`, out, 1: one-cycle pulse, header dropped as unroutable.
- `stray`, out, 1: one-cycle pulse, non-header flit dropped while IDLE.
- `pkt_cnt`, out, 16: packets completed; wraps from 0xFFFF to 0.

## Operation
- Reset: `Rxy`=8'h3C, `Cx`=4'hF, `DR`=8'h00, `cur`=5. `port_req`=0, `route_err`=0, `stray`=0, `pkt_cnt`=0, state IDLE.
- Configuration: `cfg_we` in IDLE loads all four config registers at the clock edge. `cfg_we` in ROUTE sets a pending flag and captures the values; they are applied on the cycle the FSM returns to IDLE. A later write overwrites earlier pending values.
- Comparators, unsigned: `N1 = y_dst<y_cur`, `S1 = y_cur<y_dst`, `E1 = x_cur<x_dst`, `W1 = x_dst<x_cur`.
- Minimal route: standard LBDR equations per port, masked by `Cx`. Example: `E = (E1&~N1&~S1 | E1&N1&Ren | E1&S1&Res) & Ce`.
- Local: L = all of N1, S1, E1, W1 zero.
- Deroute: applies when the minimal result is empty and L=0.
  - Primary direction priority is N, S, E, W; the first asserted comparator is primary.
  - The port is taken from that direction's `DR` code.
  - If that port's `Cx` bit is 0, pulse `route_err` and drop the header.
- FSM states:
  - IDLE: `in_ready`=1.
    - HEADER accepted: compute route, register `port_req`, go to ROUTE.
    - HEAD_TAIL accepted: assert `port_req` for one transfer, go to ROUTE with `last` set.
    - PAYLOAD/TAIL accepted: pulse `stray`, drop the flit, stay in IDLE.
    - Unroutable header: pulse `route_err`, drop it, stay in IDLE.
  - ROUTE: `in_ready = in_valid & out_ready`; `port_req` is held.
    - TAIL transferred, or the single HEAD_TAIL transfer: clear `port_req`, increment `pkt_cnt`, go to IDLE.
    - A HEADER seen in ROUTE is stalled (`in_ready`=0) and `stray` is pulsed once per occurrence. The packet is not aborted.
- Reset mid-packet returns the block to IDLE immediately; the held route is lost.

## Timing
- Header accepted at cycle t → `port_req` valid from t+1. The first body transfer is at t+1 at the earliest.
- Tail transferred at t → `port_req`=0 and state IDLE at t+1. A new header can be accepted at t+1, giving back-to-back packets with no bubble beyond the route cycle.
- `route_err`, `stray` and the `pkt_cnt` increment become visible at t+1.
- `in_ready` is combinational from state, `in_valid` and `out_ready`. There is no combinational path from `in_dst` to any output.

## Structure
- Package `lbdr_pkg` holds:
  - flit-id constants: PAYLOAD=3'b000, HEADER=3'b001, TAIL=3'b100, HEAD_TAIL=3'b101;
  - the port index enum {N,E,W,S,L};
  - the FSM state enum;
  - the reset constants 8'h3C, 4'hF, 8'h00, 5.
- Sub-module `lbdr_route_calc` is purely combinational: comparators, minimal logic, deroute selection, and outputs `{port_onehot, unroutable}`. The FSM and registers live in the top module.

## Test plan
- Reset values, `cur`=5: dst=0 HEADER → `port_req`=W (Rwn=1, Rnw=0) at t+1. dst=5 → L. dst=15 → E (Res=1, Rse=0).
- Deroute: `Cx`=4'b1101, `DR[E]`=11, dst=7 → minimal E is masked, so `port_req`=S. The same case with `Cx`=4'b0101 → `route_err` pulse and state stays IDLE.
- Packet hold: HEADER, 3 PAYLOAD, TAIL with `out_ready` toggling 1,0,1,… → `port_req` constant throughout and `in_ready` follows `out_ready`. `port_req`=0 the cycle after the TAIL transfer; `pkt_cnt`=1.
- HEAD_TAIL followed immediately by a HEADER → one-cycle route, `pkt_cnt`=1, and the second header is accepted on the next IDLE cycle.
- `cfg_we` during ROUTE with `cfg_addr`=0 → routing for the current packet is unchanged. The next header, dst=5, routes S+E-class instead of L: verify that `cur`=0 is applied only after the return to IDLE.
- Error paths: a PAYLOAD in IDLE → `stray` pulse and no `port_req`. `rst` mid-packet → `port_req`=0 next cycle.
